// File: rtl/trace_readout_pkg.sv
// Shared types and constants for the trace readout path: FSM states, header bytes
// and the packet-to-byte sizing helper.
package trace_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_FETCH,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [7:0] HDR_SOF   = 8'hA5;
  localparam logic [7:0] HDR_EOF   = 8'h5A;
  localparam int         HDR_BYTES = 4;

  function automatic int bytes_per_packet(input int packet_width);
    return packet_width / 8;
  endfunction

endpackage

// File: rtl/trace_readout_byte_serializer.sv
// trace_byte_serializer: holds one packet and presents it LSB-first as bytes under
// valid/ready, flagging the cycle in which the final byte is accepted.
module trace_byte_serializer
  import trace_readout_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             last_accept
);

  localparam int NUM_BYTES = bytes_per_packet(WIDTH);
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Flush beats load beats advance, so an abort never counts a final byte.
  always_comb begin
    shift_d     = shift_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    last_accept = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      shift_d = load_data;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (valid_q && tx_ready) begin
      if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
        valid_d     = 1'b0;
        last_accept = 1'b1;
      end else begin
        shift_d = shift_q >> 8;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign tx_data  = shift_q[7:0];
  assign tx_valid = valid_q;

endmodule

// File: rtl/trace_readout.sv
// trace_readout: walks the capture memory oldest-to-newest and streams each packet as bytes.
// Define TRACE_READOUT_HEADER_EN to prepend a header: SOF, count[15:8], count[7:0], EOF.
module trace_readout
  import trace_readout_pkg::*;
#(
  parameter int SAMPLE_PACKET_WIDTH = 16,
  parameter int ADDR_WIDTH          = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_WIDTH-1:0]          wrPtr,
  input  logic                           wrapped,
  output logic                           memRdEn,
  output logic [ADDR_WIDTH-1:0]          memAddr,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] memRdData,
  output logic [7:0]                     txData,
  output logic                           txValid,
  input  logic                           txReady,
  output logic                           busy,
  output logic                           done
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  done_q, done_d;
  logic                  ser_load, ser_flush, ser_last, ser_valid;
  logic [7:0]            ser_data;
`ifdef TRACE_READOUT_HEADER_EN
  logic [1:0]            hdr_idx_q, hdr_idx_d;
  logic [15:0]           count16;
  logic [7:0]            hdr_byte;

  always_comb begin
    count16                = '0;
    count16[ADDR_WIDTH:0]  = count_q;
    case (hdr_idx_q)
      2'd0:    hdr_byte = HDR_SOF;
      2'd1:    hdr_byte = count16[15:8];
      2'd2:    hdr_byte = count16[7:0];
      default: hdr_byte = HDR_EOF;
    endcase
  end
`endif

  // A wrapped buffer holds a full memory of packets, oldest at the write pointer.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    done_d    = 1'b0;
    ser_load  = 1'b0;
    ser_flush = 1'b0;
`ifdef TRACE_READOUT_HEADER_EN
    hdr_idx_d = hdr_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_ptr_d = wrapped ? wrPtr : '0;
          count_d  = wrapped ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, wrPtr};
`ifdef TRACE_READOUT_HEADER_EN
          hdr_idx_d = '0;
          state_d   = ST_HEADER;
`else
          state_d   = ST_FETCH;
`endif
        end
      end
`ifdef TRACE_READOUT_HEADER_EN
      ST_HEADER: begin
        if (txReady) begin
          if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
            if (count_q == '0) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            hdr_idx_d = hdr_idx_q + 1'b1;
          end
        end
      end
`endif
      ST_FETCH: begin
        if (count_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
          if (count_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      ser_flush = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
`ifdef TRACE_READOUT_HEADER_EN
      hdr_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
`ifdef TRACE_READOUT_HEADER_EN
      hdr_idx_q <= hdr_idx_d;
`endif
    end
  end

  trace_byte_serializer #(
    .WIDTH(SAMPLE_PACKET_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .flush       (ser_flush),
    .load        (ser_load),
    .load_data   (memRdData),
    .tx_ready    (txReady),
    .tx_data     (ser_data),
    .tx_valid    (ser_valid),
    .last_accept (ser_last)
  );

`ifdef TRACE_READOUT_HEADER_EN
  assign txValid = (state_q == ST_HEADER) || ser_valid;
  assign txData  = (state_q == ST_HEADER) ? hdr_byte : ser_data;
`else
  assign txValid = ser_valid;
  assign txData  = ser_data;
`endif
  assign memRdEn = (state_q == ST_FETCH) && (count_q != '0);
  assign memAddr = rd_ptr_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_trace_readout.sv
// Self-checking bench for trace_readout: directed cases plus randomized captures
// compared against a queue-based model of the readout byte stream.
module tb_trace_readout;

  localparam int AW    = 2;
  localparam int PW    = 16;
  localparam int DEPTH = 4;
`ifdef TRACE_READOUT_HEADER_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif

  logic          clk, reset, start, abort;
  logic [AW-1:0] wrPtr;
  logic          wrapped;
  logic          memRdEn;
  logic [AW-1:0] memAddr;
  logic [PW-1:0] memRdData;
  logic [7:0]    txData;
  logic          txValid, txReady, busy, done;

  int checks, failures;
  logic [15:0] mem [DEPTH];
  logic [7:0]  byteQ[$];
  logic [7:0]  expBytes[$];
  int          addrQ[$];
  int          expAddr[$];
  int doneCount, busyCycles, cycleCount, doneCycle, lastAcceptCycle, expBusy, stopAfter;
  bit readyRandom, heldPending, skipNext;
  logic [7:0] heldData;

  trace_readout #(
    .SAMPLE_PACKET_WIDTH(PW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .wrPtr     (wrPtr),
    .wrapped   (wrapped),
    .memRdEn   (memRdEn),
    .memAddr   (memAddr),
    .memRdData (memRdData),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture memory: read data appears the cycle after the strobe
  always @(posedge clk) begin
    if (memRdEn) memRdData <= mem[memAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Downstream ready: always-on, random, or forced low once a byte budget is reached
  initial begin
    txReady = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stopAfter >= 0 && byteQ.size() >= stopAfter) txReady = 1'b0;
      else if (readyRandom) txReady = 1'($urandom_range(0, 1));
      else txReady = 1'b1;
    end
  end

  // Observe the stream between edges: handshakes, read addresses, done, and byte holding
  always @(negedge clk) begin
    cycleCount++;
    if (busy) busyCycles++;
    if (memRdEn) addrQ.push_back(int'(memAddr));
    if (done) begin
      doneCount++;
      doneCycle = cycleCount;
      checkOutput("done_busy_low", 32'(busy), 32'd0);
    end
    if (heldPending && !skipNext) begin
      checkOutput("hold_valid", 32'(txValid), 32'd1);
      checkOutput("hold_data", 32'(txData), 32'(heldData));
    end
    heldPending = txValid && !txReady;
    heldData    = txData;
    skipNext    = abort || reset;
    if (txValid && txReady) begin
      byteQ.push_back(txData);
      lastAcceptCycle = cycleCount;
    end
  end

  initial begin
    #400000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic fillMem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
  endtask

  // Reference model: oldest-to-newest packet walk, low byte first, optional header
  task automatic buildExpected(input int w, input bit wr);
    int base, cnt, a;
    expBytes.delete();
    expAddr.delete();
    base = wr ? w : 0;
    cnt  = wr ? DEPTH : w;
    if (HDR_N > 0) begin
      expBytes.push_back(8'hA5);
      expBytes.push_back(8'(cnt >> 8));
      expBytes.push_back(8'(cnt & 255));
      expBytes.push_back(8'h5A);
    end
    for (int i = 0; i < cnt; i++) begin
      a = (base + i) % DEPTH;
      expAddr.push_back(a);
      expBytes.push_back(mem[a][7:0]);
      expBytes.push_back(mem[a][15:8]);
    end
    expBusy = HDR_N + ((cnt == 0) ? ((HDR_N == 0) ? 1 : 0) : cnt * (PW / 8 + 2));
  endtask

  // Pulse start for one edge, then scramble the capture pointers (they must be ignored)
  task automatic applyStimulus(input logic [AW-1:0] w, input logic wr);
    @(posedge clk);
    #2;
    byteQ.delete();
    addrQ.delete();
    doneCount = 0;
    busyCycles = 0;
    doneCycle = -1;
    lastAcceptCycle = -1;
    wrPtr = w;
    wrapped = wr;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wrPtr = AW'($urandom);
    wrapped = 1'($urandom);
  endtask

  task automatic awaitCompletion(input bit extraStart);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (extraStart) start = busy && (i % 3 == 0);
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkRun(input bit checkBusy);
    checkOutput("byte_count", byteQ.size(), expBytes.size());
    for (int i = 0; i < expBytes.size() && i < byteQ.size(); i++)
      checkOutput("byte", 32'(byteQ[i]), 32'(expBytes[i]));
    checkOutput("addr_count", addrQ.size(), expAddr.size());
    for (int i = 0; i < expAddr.size() && i < addrQ.size(); i++)
      checkOutput("mem_addr", addrQ[i], expAddr[i]);
    checkOutput("done_count", doneCount, 1);
    if (expBytes.size() > 0) checkOutput("done_timing", doneCycle, lastAcceptCycle + 1);
    if (checkBusy) checkOutput("busy_cycles", busyCycles, expBusy);
  endtask

  // Stall mid-way through the second packet, then kill the readout and restart it
  task automatic abortMidPacket(input bit useReset);
    bit held;
    held = 1'b0;
    buildExpected(3, 1'b0);
    applyStimulus(2'd3, 1'b0);
    stopAfter = HDR_N + 3;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txValid && !txReady) begin
        held = 1'b1;
        break;
      end
    end
    checkOutput("abort_setup", 32'(held), 32'd1);
    checkOutput("abort_held_byte", 32'(txData), 32'(expBytes[HDR_N + 3]));
    @(posedge clk);
    #2;
    if (useReset) reset = 1'b1;
    else abort = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_txvalid", 32'(txValid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rden", 32'(memRdEn), 32'd0);
    stopAfter = -1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", doneCount, 0);
    buildExpected(3, 1'b0);
    applyStimulus(2'd3, 1'b0);
    awaitCompletion(1'b0);
    checkRun(1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    wrPtr = '0;
    wrapped = 1'b0;
    stopAfter = -1;
    readyRandom = 1'b0;
    heldPending = 1'b0;
    skipNext = 1'b0;
    cycleCount = 0;
    doneCount = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_txvalid", 32'(txValid), 32'd0);
    checkOutput("rst_txdata", 32'(txData), 32'd0);
    checkOutput("rst_rden", 32'(memRdEn), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    $display("[TB] non-wrapped capture");
    mem[0] = 16'h1122;
    mem[1] = 16'h3344;
    mem[2] = 16'h5566;
    mem[3] = 16'h7788;
    buildExpected(3, 1'b0);
    applyStimulus(2'd3, 1'b0);
`ifndef TRACE_READOUT_HEADER_EN
    @(negedge clk);
    checkOutput("lat_fetch_rden", 32'(memRdEn), 32'd1);
    checkOutput("lat_fetch_addr", 32'(memAddr), 32'd0);
    @(negedge clk);
    checkOutput("lat_wait_rden", 32'(memRdEn), 32'd0);
    checkOutput("lat_wait_valid", 32'(txValid), 32'd0);
    @(negedge clk);
    checkOutput("lat_send_valid", 32'(txValid), 32'd1);
    checkOutput("lat_send_data", 32'(txData), 32'h22);
`endif
    awaitCompletion(1'b0);
    checkRun(1'b1);

    $display("[TB] wrapped capture");
    fillMem();
    buildExpected(2, 1'b1);
    applyStimulus(2'd2, 1'b1);
    awaitCompletion(1'b0);
    checkRun(1'b1);

    $display("[TB] empty capture");
    buildExpected(0, 1'b0);
    applyStimulus(2'd0, 1'b0);
    awaitCompletion(1'b0);
    checkRun(1'b1);

    $display("[TB] backpressure");
    readyRandom = 1'b1;
    fillMem();
    buildExpected(1, 1'b1);
    applyStimulus(2'd1, 1'b1);
    awaitCompletion(1'b0);
    checkRun(1'b0);
    readyRandom = 1'b0;

    $display("[TB] start while busy");
    fillMem();
    buildExpected(3, 1'b0);
    applyStimulus(2'd3, 1'b0);
    awaitCompletion(1'b1);
    checkRun(1'b1);

    $display("[TB] abort and reset mid-packet");
    fillMem();
    abortMidPacket(1'b0);
    abortMidPacket(1'b1);

    $display("[TB] randomized captures");
    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] w;
      logic wr;
      bit extra;
      w = AW'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      extra = 1'($urandom_range(0, 1));
      readyRandom = 1'($urandom_range(0, 1));
      fillMem();
      buildExpected(int'(w), wr);
      applyStimulus(w, wr);
      awaitCompletion(extra);
      checkRun(!readyRandom);
    end
    readyRandom = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_readout.md
# trace_readout

Reader side of the capture trace buffer. After a capture completes, the block walks the sample-packet memory from the oldest packet to the newest and serializes each packet into bytes on a valid/ready byte stream toward the host link. It sits between the capture buffer's read port and the host transmit path. It owns no sample storage.

## Interface
Parameters:
- SAMPLE_PACKET_WIDTH, 16, width of one stored packet; must be a multiple of 8.
- ADDR_WIDTH, 10, trace memory address width; depth is 2^ADDR_WIDTH; must be 15 or less.

Ports:
- clk  in  1  single clock; all logic is posedge.
- reset  in  1  reset is synchronous and active-high.
- start  in  1  readout request; sampled only in IDLE.
- abort  in  1  stops readout; returns the block to IDLE.
- wrPtr  in  ADDR_WIDTH  capture write pointer, the next address to be written.
- wrapped  in  1  capture buffer has wrapped at least once.
- memRdEn  out  1  memory read strobe.
- memAddr  out  ADDR_WIDTH  memory read address.
- memRdData  in  SAMPLE_PACKET_WIDTH  read data, valid the cycle after memRdEn.
- txData  out  8  output byte.
- txValid  out  1  byte valid.
- txReady  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last byte is accepted.

## Operation
- States: IDLE, HEADER (only when the feature is compiled in), FETCH, WAIT, SEND.
- In IDLE with start=1:
  - Latch the base address and packet count.
    - If wrapped=1: base = wrPtr and count = 2^ADDR_WIDTH.
    - If wrapped=0: base = 0 and count = wrPtr.
  - The count register is ADDR_WIDTH+1 bits wide.
  - Next state is HEADER, or FETCH when the feature is not compiled in.
- If count = 0, skip FETCH/WAIT/SEND and complete immediately: pulse done, go to IDLE.
- FETCH: assert memRdEn=1 with memAddr = rdPtr.
- WAIT: at the end of this cycle, load memRdData into the shift register.
- SEND:
  - Present the packet as SAMPLE_PACKET_WIDTH/8 bytes, least significant byte first.
  - On each accepted byte (txValid & txReady), shift to the next byte.
  - After the last byte: increment rdPtr modulo 2^ADDR_WIDTH (wrapping from all-ones to 0) and decrement the remaining count.
  - If the remaining count is 0: pulse done and go to IDLE. Otherwise go to FETCH.
- Handshake rules:
  - Once txValid rises, txData and txValid hold until txReady is seen.
  - The only exceptions are abort and reset.
- start while busy=1 is ignored. start and abort in the same IDLE cycle: abort wins and nothing starts.
- abort in any state: next cycle is IDLE with txValid=0 and memRdEn=0. done is not pulsed.
- wrPtr and wrapped are only sampled at start. Changes during readout have no effect.

## Timing
- Reset values: txValid=0, txData=0, memRdEn=0, memAddr=0, busy=0, done=0. State is IDLE, counters are 0.
- Reset mid-readout has the same effect as abort, including any in-flight byte.
- Latency, with the header not compiled in and start sampled at edge N:
  - FETCH in cycle N+1, with memRdEn high.
  - WAIT in cycle N+2.
  - txValid high from edge N+3.
- Throughput with txReady held at 1: one packet every SAMPLE_PACKET_WIDTH/8 + 2 cycles.
- done is high for the cycle immediately after the edge that accepts the final byte. busy falls in that same cycle.

## Configuration
- TRACE_READOUT_HEADER_EN defined:
  - After start, the HEADER state sends 4 bytes before the first FETCH: 0xA5, count[15:8], count[7:0], 0x5A.
  - count is zero-extended to 16 bits.
  - The header is sent even when count = 0; completion follows the 0x5A byte.
- TRACE_READOUT_HEADER_EN undefined: no HEADER state and no header bytes. The first byte out is packet 0, low byte.

## Structure
- Shared package holds:
  - the state enum;
  - the header byte constants HDR_SOF = 0xA5 and HDR_EOF = 0x5A;
  - the bytes-per-packet constant, SAMPLE_PACKET_WIDTH/8.
- One sub-module is natural: trace_byte_serializer. It loads a packet, presents bytes LSB-first under valid/ready, and reports a last-byte-accepted signal.
- The address/count FSM stays in the top.

## Test plan
- Non-wrapped capture: wrPtr=3, wrapped=0, mem[0..2]=0x1122, 0x3344, 0x5566, txReady=1.
  - Required bytes: 22 11 44 33 66 55, then one done pulse.
  - With the header: A5 00 03 5A first.
- Wrapped capture: ADDR_WIDTH=2, wrPtr=2, wrapped=1.
  - memAddr sequence must be 2, 3, 0, 1, and 8 data bytes must follow.
- Backpressure: txReady toggled pseudo-randomly.
  - txData must stay stable while txValid=1 and txReady=0.
  - No byte is lost or duplicated.
- Empty capture: wrPtr=0, wrapped=0.
  - No memRdEn is ever asserted.
  - done pulses with busy high for a single cycle (headerless build), or after the 4 header bytes (header build).
- Abort or reset while txValid=1 and txReady=0 in the middle of packet 2.
  - Next cycle: txValid=0, busy=0, no done pulse.
  - A new start then restarts cleanly from base.
- start pulsed again during readout: no effect, and the byte stream matches the single-start case.
